// File: rtl/rv32i_mon_pkg.sv
// Shared constants and types for the rv32i run monitor.
package rv32i_mon_pkg;

    // Reasons a run stopped, as presented on halt_reason.
    localparam logic [1:0] HALT_NONE    = 2'd0;
    localparam logic [1:0] HALT_ENV     = 2'd1;
    localparam logic [1:0] HALT_LOOP    = 2'd2;
    localparam logic [1:0] HALT_TIMEOUT = 2'd3;

    // Instruction words that end a program.
    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_EMPTY  = 32'h0000_0000;

    // Supervisor states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_t;

    // True for the environment-call encodings (ECALL / EBREAK).
    function automatic logic is_env_instr(input logic [31:0] word);
        return (word == INSTR_ECALL) || (word == INSTR_EBREAK);
    endfunction

endpackage

// File: rtl/mon_trace_fifo.sv
// Synchronous FIFO for trace entries. The head entry is driven straight from
// registered storage and the registered read pointer, so an entry written at
// one edge is visible right after it. A push into a full FIFO with no pop in
// the same cycle is dropped and flagged on o-side "drop".
module mon_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_do_push = push && (!w_full || w_do_pop);
    assign drop      = push && w_full && !w_do_pop;
    // Outputs read as zero while nothing is stored.
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    // Storage write.
    // NOTE: the data array carries no reset; validity is tracked by the
    // pointers and count alone, which keeps the array as plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_run_monitor.sv
// Run supervisor for the rv32i core: watches the fetch stream, decides when
// the program has ended, counts cycles and fetches, and buffers a trace of
// every fetch for a ready/valid consumer.
module rv32i_run_monitor
    import rv32i_mon_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int CNT_W       = 32,
    parameter int MAX_CYCLES  = 64,
    parameter int TRACE_DEPTH = 8,
    parameter int SELF_LOOP_N = 2,
    parameter bit HALT_ON_ENV = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              instr_valid,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic [31:0]       instruction,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [CNT_W-1:0]  trace_index,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [31:0]       trace_instr,
    output logic              busy,
    output logic              done,
    output logic [1:0]        halt_reason,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count,
    output logic              trace_overflow
);

    localparam int LOOP_W  = $clog2(SELF_LOOP_N + 1);
    localparam int ENTRY_W = CNT_W + ADDR_W + 32;

    mon_state_t        r_state;
    mon_state_t        w_state_next;
    logic              w_start_run;

    logic [CNT_W-1:0]  r_cycle_count;
    logic [CNT_W-1:0]  r_instr_count;
    logic [1:0]        r_halt_reason;
    logic              r_overflow;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_have_last;
    logic [LOOP_W-1:0] r_loop_cnt;

    logic              w_run;
    logic              w_fetch;
    logic [CNT_W-1:0]  w_cycle_next;
    logic [LOOP_W-1:0] w_loop_next;
    logic              w_env_hit;
    logic              w_loop_hit;
    logic              w_timeout_hit;
    logic              w_halt;
    logic [1:0]        w_halt_code;

    logic [ENTRY_W-1:0] w_fifo_dout;
    logic               w_fifo_empty;
    logic               w_fifo_drop;

    // Halt detection on the current RUN cycle.
    assign w_run         = (r_state == ST_RUN);
    assign w_fetch       = w_run && instr_valid;
    assign w_cycle_next  = r_cycle_count + CNT_W'(1);
    assign w_loop_next   = (r_have_last && (instr_addr == r_last_addr))
                         ? r_loop_cnt + LOOP_W'(1) : '0;
    assign w_env_hit     = w_fetch && ((HALT_ON_ENV && is_env_instr(instruction))
                                       || (instruction == INSTR_EMPTY));
    assign w_loop_hit    = w_fetch && (w_loop_next == LOOP_W'(SELF_LOOP_N));
    assign w_timeout_hit = w_run && (w_cycle_next == CNT_W'(MAX_CYCLES));
    assign w_halt        = w_env_hit || w_loop_hit || w_timeout_hit;
    assign w_halt_code   = w_env_hit  ? HALT_ENV  :
                           w_loop_hit ? HALT_LOOP :
                           w_timeout_hit ? HALT_TIMEOUT : HALT_NONE;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start is only honoured from IDLE or DONE.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_start_run  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_start_run  = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_halt) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_fifo_empty) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Counters, loop tracker and latched halt reason; frozen outside RUN.
    always_ff @(posedge clk) begin
        if (rst || w_start_run) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
            r_halt_reason <= HALT_NONE;
            r_last_addr   <= '0;
            r_have_last   <= 1'b0;
            r_loop_cnt    <= '0;
        end else if (w_run) begin
            r_cycle_count <= w_cycle_next;
            if (instr_valid) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
                r_last_addr   <= instr_addr;
                r_have_last   <= 1'b1;
                r_loop_cnt    <= w_loop_next;
            end
            if (w_halt) begin
                r_halt_reason <= w_halt_code;
            end
        end
    end

    // Sticky record of any trace entry lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (rst || w_start_run) begin
            r_overflow <= 1'b0;
        end else if (w_fifo_drop) begin
            r_overflow <= 1'b1;
        end
    end

    mon_trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (w_start_run),
        .push  (w_fetch),
        .pop   (trace_valid && trace_ready),
        .din   ({r_instr_count, instr_addr, instruction}),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty),
        .drop  (w_fifo_drop)
    );

    assign trace_valid    = !w_fifo_empty;
    assign {trace_index, trace_addr, trace_instr} = w_fifo_dout;
    assign busy           = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done           = (r_state == ST_DONE);
    assign halt_reason    = r_halt_reason;
    assign cycle_count    = r_cycle_count;
    assign instr_count    = r_instr_count;
    assign trace_overflow = r_overflow;

endmodule

// File: tb/tb_rv32i_run_monitor.sv
// Directed bench for rv32i_run_monitor with default parameters
// (MAX_CYCLES=64, TRACE_DEPTH=8, SELF_LOOP_N=2, HALT_ON_ENV=1).
module tb_rv32i_run_monitor;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 32;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] JSELF  = 32'h0000_006F;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              instr_valid;
    logic [ADDR_W-1:0] instr_addr;
    logic [31:0]       instruction;
    logic              trace_valid;
    logic              trace_ready;
    logic [CNT_W-1:0]  trace_index;
    logic [ADDR_W-1:0] trace_addr;
    logic [31:0]       trace_instr;
    logic              busy;
    logic              done;
    logic [1:0]        halt_reason;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  instr_count;
    logic              trace_overflow;

    typedef struct packed {
        logic [31:0] idx;
        logic [15:0] addr;
        logic [31:0] instr;
    } ent_t;

    ent_t        obs_q[$];
    ent_t        exp_q[$];
    logic [31:0] exp_idx;
    int          checks   = 0;
    int          failures = 0;

    rv32i_run_monitor dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .instr_valid    (instr_valid),
        .instr_addr     (instr_addr),
        .instruction    (instruction),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_index    (trace_index),
        .trace_addr     (trace_addr),
        .trace_instr    (trace_instr),
        .busy           (busy),
        .done           (done),
        .halt_reason    (halt_reason),
        .cycle_count    (cycle_count),
        .instr_count    (instr_count),
        .trace_overflow (trace_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record any handshake completing at the coming edge, then advance one cycle.
    task automatic step();
        if (trace_valid && trace_ready) begin
            obs_q.push_back({trace_index, trace_addr, trace_instr});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] a, input logic [31:0] w);
        instr_valid = 1'b1;
        instr_addr  = a;
        instruction = w;
        exp_q.push_back({exp_idx, a, w});
        exp_idx = exp_idx + 32'd1;
        step();
        instr_valid = 1'b0;
        instruction = NOP;
    endtask

    task automatic begin_run();
        start = 1'b1;
        step();
        start = 1'b0;
        obs_q.delete();
        exp_q.delete();
        exp_idx = '0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && !done; i++) begin
            step();
        end
        check({tag, " done"}, done, 1);
    endtask

    task automatic compare_trace(input string tag);
        int n;
        check({tag, " entries"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s idx[%0d]", tag, i),   obs_q[i].idx,   exp_q[i].idx);
            check($sformatf("%s addr[%0d]", tag, i),  obs_q[i].addr,  exp_q[i].addr);
            check($sformatf("%s instr[%0d]", tag, i), obs_q[i].instr, exp_q[i].instr);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " trace_valid"}, trace_valid, 0);
        check({tag, " busy"},        busy, 0);
        check({tag, " done"},        done, 0);
        check({tag, " halt"},        halt_reason, 0);
        check({tag, " cycles"},      cycle_count, 0);
        check({tag, " instrs"},      instr_count, 0);
        check({tag, " overflow"},    trace_overflow, 0);
        check({tag, " index"},       trace_index, 0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        instr_valid = 1'b0;
        instr_addr  = '0;
        instruction = NOP;
        trace_ready = 1'b1;
        exp_idx     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, and IDLE does not count.
        check_cleared("reset");
        repeat (3) step();
        check("idle cycles", cycle_count, 0);
        check("idle busy", busy, 0);

        // EBREAK halt after five ordinary fetches.
        begin_run();
        check("ebreak busy at start", busy, 1);
        for (int i = 0; i < 5; i++) begin
            fetch(16'(i * 4), NOP + 32'(i << 7));
        end
        fetch(16'h0014, EBREAK);
        check("ebreak halt", halt_reason, 1);
        check("ebreak instrs", instr_count, 6);
        check("ebreak cycles", cycle_count, 6);
        check("ebreak draining", busy, 1);
        wait_done("ebreak");
        compare_trace("ebreak");
        repeat (3) step();
        check("ebreak done holds", done, 1);
        check("ebreak halt holds", halt_reason, 1);
        check("ebreak cycles frozen", cycle_count, 6);

        // Self-loop halt; a start pulse mid-run must be ignored.
        begin_run();
        check("loop cleared cycles", cycle_count, 0);
        check("loop cleared halt", halt_reason, 0);
        fetch(16'h0008, NOP);
        start = 1'b1;
        fetch(16'h000C, JSELF);
        start = 1'b0;
        fetch(16'h000C, JSELF);
        check("loop not yet", halt_reason, 0);
        check("loop still running", busy, 1);
        fetch(16'h000C, JSELF);
        check("loop halt", halt_reason, 2);
        check("loop instrs", instr_count, 4);
        check("loop cycles", cycle_count, 4);
        wait_done("loop");
        compare_trace("loop");

        // Timeout after 64 distinct ordinary fetches.
        begin_run();
        for (int i = 0; i < 63; i++) begin
            fetch(16'(i * 4), NOP);
        end
        check("timeout not yet", halt_reason, 0);
        check("timeout cycles 63", cycle_count, 63);
        fetch(16'd252, NOP);
        check("timeout halt", halt_reason, 3);
        check("timeout cycles", cycle_count, 64);
        check("timeout instrs", instr_count, 64);
        wait_done("timeout");
        compare_trace("timeout");
        check("timeout overflow", trace_overflow, 0);

        // Backpressure: ten fetches into an eight-deep FIFO.
        trace_ready = 1'b0;
        begin_run();
        for (int i = 0; i < 9; i++) begin
            fetch(16'(16'h0100 + i * 4), NOP);
        end
        fetch(16'h0124, ECALL);
        check("bp halt", halt_reason, 1);
        check("bp instrs", instr_count, 10);
        check("bp overflow", trace_overflow, 1);
        check("bp head valid", trace_valid, 1);
        check("bp head index", trace_index, 0);
        repeat (3) step();
        check("bp stalled busy", busy, 1);
        check("bp stalled not done", done, 0);
        trace_ready = 1'b1;
        wait_done("bp");
        while (exp_q.size() > 8) begin
            void'(exp_q.pop_back());
        end
        compare_trace("bp");
        check("bp overflow sticky", trace_overflow, 1);

        // ECALL on the timeout cycle: ENV wins.
        begin_run();
        check("simul overflow cleared", trace_overflow, 0);
        for (int i = 0; i < 63; i++) begin
            fetch(16'(16'h0200 + i * 4), NOP);
        end
        fetch(16'h02FC, ECALL);
        check("simul halt", halt_reason, 1);
        check("simul cycles", cycle_count, 64);
        check("simul instrs", instr_count, 64);
        wait_done("simul");
        compare_trace("simul");

        // Reset in RUN cycle 5 with three entries buffered.
        trace_ready = 1'b0;
        begin_run();
        fetch(16'h0300, NOP);
        fetch(16'h0304, NOP);
        fetch(16'h0308, NOP);
        step();
        check("mid holding", trace_valid, 1);
        check("mid cycles", cycle_count, 4);
        check("mid instrs", instr_count, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_cleared("mid reset");
        trace_ready = 1'b1;
        begin_run();
        fetch(16'h0040, NOP);
        fetch(16'h0044, EBREAK);
        check("rerun halt", halt_reason, 1);
        check("rerun instrs", instr_count, 2);
        wait_done("rerun");
        compare_trace("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
